// File: rtl/id_exe_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_exe_pipe_reg
//
// ID/EXE pipeline register of the 5-stage MIPS core. It captures the decoded
// controls and operands from ID on every rising clk edge and presents them to
// the EXE stage. It also does the following:
//   - inserts a bubble for a load-use hazard or a control-flow flush
//   - freezes while EXE is stalled by a downstream multicycle unit
//   - raises lu_stall so that PC and IF/ID hold the dependent instruction
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   hold                     EXE stall: every e_* output keeps its value
//   flush                    branch/jump taken: the ID instruction is wrong-path
//   d_valid                  ID slot holds a real instruction
//   d_wreg .. d_jal          decoded single-bit controls
//   d_aluc                   ALU operation
//   d_rn                     destination register
//   d_rs, d_rt               source register numbers
//   d_use_rs, d_use_rt       ID instruction actually reads rs / rt
//   d_qa, d_qb               forwarded register operands
//   d_imm                    extended immediate
//   d_pc4                    PC+4
//   e_*                      registered copies of the above, toward EXE
//   lu_stall                 load-use stall request to PC and IF/ID
// ---------------------------------------------------------------------------
module id_exe_pipe_reg #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          flush,
  input  logic          d_valid,
  input  logic          d_wreg,
  input  logic          d_m2reg,
  input  logic          d_wmem,
  input  logic          d_aluimm,
  input  logic          d_shift,
  input  logic          d_jal,
  input  logic [CW-1:0] d_aluc,
  input  logic [RW-1:0] d_rn,
  input  logic [RW-1:0] d_rs,
  input  logic [RW-1:0] d_rt,
  input  logic          d_use_rs,
  input  logic          d_use_rt,
  input  logic [DW-1:0] d_qa,
  input  logic [DW-1:0] d_qb,
  input  logic [DW-1:0] d_imm,
  input  logic [DW-1:0] d_pc4,
  output logic          e_valid,
  output logic          e_wreg,
  output logic          e_m2reg,
  output logic          e_wmem,
  output logic          e_aluimm,
  output logic          e_shift,
  output logic          e_jal,
  output logic [CW-1:0] e_aluc,
  output logic [RW-1:0] e_rn,
  output logic [DW-1:0] e_qa,
  output logic [DW-1:0] e_qb,
  output logic [DW-1:0] e_imm,
  output logic [DW-1:0] e_pc4,
  output logic          lu_stall
);

  // Remembers a flush that arrived while frozen, so that the flush is applied
  // on the first edge that is not held.
  logic flush_pend;

  logic rs_hit;
  logic rt_hit;
  logic ex_is_load;
  logic bubble;

  // A load that is in EXE writes a register that is not $0. If the ID
  // instruction reads that register, the loaded data is not ready in time.
  assign ex_is_load = e_valid & e_m2reg & e_wreg & (e_rn != '0);
  assign rs_hit     = d_use_rs & (d_rs == e_rn);
  assign rt_hit     = d_use_rt & (d_rt == e_rn);

  // Gated by hold: the pipe is frozen anyway. Gating it here keeps a
  // stall-and-hold overlap from costing two bubbles.
  assign lu_stall = ex_is_load & (rs_hit | rt_hit) & d_valid & ~hold;

  // A flush takes priority over a load-use stall. Both cases produce one
  // bubble, so the two causes can share the same path.
  assign bubble = flush | flush_pend | lu_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend <= 1'b0;
      e_valid    <= 1'b0;
      e_wreg     <= 1'b0;
      e_m2reg    <= 1'b0;
      e_wmem     <= 1'b0;
      e_aluimm   <= 1'b0;
      e_shift    <= 1'b0;
      e_jal      <= 1'b0;
      e_aluc     <= '0;
      e_rn       <= '0;
      e_qa       <= '0;
      e_qb       <= '0;
      e_imm      <= '0;
      e_pc4      <= '0;
    end else if (hold) begin
      if (flush) begin
        flush_pend <= 1'b1;
      end
    end else begin
      flush_pend <= 1'b0;
      // The payload is always loaded from ID, even for a bubble. This keeps
      // the don't-care fields deterministic in waveforms.
      e_aluimm   <= d_aluimm;
      e_shift    <= d_shift;
      e_aluc     <= d_aluc;
      e_rn       <= d_rn;
      e_qa       <= d_qa;
      e_qb       <= d_qb;
      e_imm      <= d_imm;
      e_pc4      <= d_pc4;
      if (bubble) begin
        e_valid  <= 1'b0;
        e_wreg   <= 1'b0;
        e_m2reg  <= 1'b0;
        e_wmem   <= 1'b0;
        e_jal    <= 1'b0;
      end else begin
        e_valid  <= d_valid;
        e_wreg   <= d_wreg;
        e_m2reg  <= d_m2reg;
        e_wmem   <= d_wmem;
        e_jal    <= d_jal;
      end
    end
  end

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_exe_pipe_reg
//
// Directed vector table for id_exe_pipe_reg. Each record describes the ID
// inputs and control for one clock cycle. Each record also gives two
// expectations:
//   - the lu_stall value before the edge
//   - the e_* values after the edge
// The records run in order. Pipeline state carries from one record to the
// next, so the multi-cycle cases below are written as consecutive records:
// load-use, hold with flush, flush with a load-use stall, and reset mid-hold.
// d_shift, d_qa and d_pc4 come from other fields of the record. This lets
// those paths be checked as well without widening the table.
// ---------------------------------------------------------------------------
module tb_id_exe_pipe_reg;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int NV = 25;

  logic          clk = 1'b0;
  logic          rst, hold, flush;
  logic          d_valid, d_wreg, d_m2reg, d_wmem, d_aluimm, d_shift, d_jal;
  logic [CW-1:0] d_aluc;
  logic [RW-1:0] d_rn, d_rs, d_rt;
  logic          d_use_rs, d_use_rt;
  logic [DW-1:0] d_qa, d_qb, d_imm, d_pc4;
  logic          e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, e_jal;
  logic [CW-1:0] e_aluc;
  logic [RW-1:0] e_rn;
  logic [DW-1:0] e_qa, e_qb, e_imm, e_pc4;
  logic          lu_stall;

  always #5 clk = ~clk;

  id_exe_pipe_reg #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .d_valid(d_valid), .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem),
    .d_aluimm(d_aluimm), .d_shift(d_shift), .d_jal(d_jal), .d_aluc(d_aluc),
    .d_rn(d_rn), .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm), .d_pc4(d_pc4),
    .e_valid(e_valid), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem),
    .e_aluimm(e_aluimm), .e_shift(e_shift), .e_jal(e_jal), .e_aluc(e_aluc),
    .e_rn(e_rn), .e_qa(e_qa), .e_qb(e_qb), .e_imm(e_imm), .e_pc4(e_pc4),
    .lu_stall(lu_stall)
  );

  typedef struct {
    logic          rst, hold, flush, dv, wreg, m2reg, wmem, jal, aluimm, use_rs, use_rt;
    logic [RW-1:0] rs, rt, rn;
    logic [CW-1:0] aluc;
    logic [DW-1:0] qb, imm;
    logic          x_lu, x_valid, x_wreg, x_m2reg, x_wmem, x_jal, x_aluimm;
    logic [RW-1:0] x_rn;
    logic [CW-1:0] x_aluc;
    logic [DW-1:0] x_qb, x_imm;
  } vec_t;

  vec_t vecs [NV];
  int   n_cmp = 0;
  int   n_bad = 0;

  // d_qa and d_pc4 are rotations, so that zero maps to zero. The reset
  // expectations then still hold.
  function automatic logic [DW-1:0] mk_qa(input logic [DW-1:0] qb);
    return {qb[7:0], qb[31:8]};
  endfunction

  function automatic logic [DW-1:0] mk_pc4(input logic [DW-1:0] imm);
    return {imm[15:0], imm[31:16]};
  endfunction

  function automatic vec_t mk(
    input logic r, h, f, dv, w, m, wm, j, ai, urs, urt,
    input logic [RW-1:0] rs, rt, rn, input logic [CW-1:0] aluc,
    input logic [DW-1:0] qb, imm,
    input logic xlu, xv, xw, xm, xwm, xj, xai,
    input logic [RW-1:0] xrn, input logic [CW-1:0] xaluc,
    input logic [DW-1:0] xqb, ximm);
    vec_t v;
    v.rst = r;  v.hold = h; v.flush = f; v.dv = dv; v.wreg = w; v.m2reg = m;
    v.wmem = wm; v.jal = j; v.aluimm = ai; v.use_rs = urs; v.use_rt = urt;
    v.rs = rs; v.rt = rt; v.rn = rn; v.aluc = aluc; v.qb = qb; v.imm = imm;
    v.x_lu = xlu; v.x_valid = xv; v.x_wreg = xw; v.x_m2reg = xm; v.x_wmem = xwm;
    v.x_jal = xj; v.x_aluimm = xai; v.x_rn = xrn; v.x_aluc = xaluc;
    v.x_qb = xqb; v.x_imm = ximm;
    return v;
  endfunction

  task automatic chk(input int idx, input string name,
                     input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %h, expected %h", idx, name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;  hold = v.hold; flush = v.flush;
    d_valid = v.dv; d_wreg = v.wreg; d_m2reg = v.m2reg; d_wmem = v.wmem;
    d_jal = v.jal; d_aluimm = v.aluimm; d_shift = v.aluimm;
    d_use_rs = v.use_rs; d_use_rt = v.use_rt;
    d_rs = v.rs; d_rt = v.rt; d_rn = v.rn; d_aluc = v.aluc;
    d_qb = v.qb; d_qa = mk_qa(v.qb); d_imm = v.imm; d_pc4 = mk_pc4(v.imm);
  endtask

  initial begin
    // Each row is: rst hold flush dv wreg m2reg wmem jal aluimm use_rs use_rt rs rt rn aluc qb imm
    //              | lu valid wreg m2reg wmem jal aluimm rn aluc qb imm
    // Reset with live ID inputs, then release.
    vecs[0]  = mk(1,0,0,1,1,0,0,0,1,0,0, 0,0,3,5, 32'hDEADBEEF,32'h10,   0,0,0,0,0,0,0, 0,0, 32'h0,32'h0);
    vecs[1]  = mk(0,0,0,1,1,0,0,0,1,0,0, 0,0,3,5, 32'hDEADBEEF,32'h10,   0,1,1,0,0,0,1, 3,5, 32'hDEADBEEF,32'h10);
    // Pass-through (rs matches e_rn, but EXE is not a load).
    vecs[2]  = mk(0,0,0,1,1,0,0,0,1,1,0, 3,0,8,2, 32'h12345678,32'hFFFFFFFC, 0,1,1,0,0,0,1, 8,2, 32'h12345678,32'hFFFFFFFC);
    // lw $9, then a dependent add: one bubble, then the add.
    vecs[3]  = mk(0,0,0,1,1,1,0,0,1,1,0, 8,0,9,0, 32'hAAAA0001,32'h4,    0,1,1,1,0,0,1, 9,0, 32'hAAAA0001,32'h4);
    vecs[4]  = mk(0,0,0,1,1,0,0,0,0,1,0, 9,0,10,2, 32'hBBBB0002,32'h0,   1,0,0,0,0,0,0, 10,2, 32'hBBBB0002,32'h0);
    vecs[5]  = mk(0,0,0,1,1,0,0,0,0,1,0, 9,0,10,2, 32'hBBBB0002,32'h0,   0,1,1,0,0,0,0, 10,2, 32'hBBBB0002,32'h0);
    // lw $0 followed by a reader of $0: no stall.
    vecs[6]  = mk(0,0,0,1,1,1,0,0,1,0,0, 0,0,0,0, 32'hCCCC0003,32'h20,   0,1,1,1,0,0,1, 0,0, 32'hCCCC0003,32'h20);
    vecs[7]  = mk(0,0,0,1,1,1,0,0,1,1,0, 0,0,11,0, 32'hCCCC0004,32'h24,  0,1,1,1,0,0,1, 11,0, 32'hCCCC0004,32'h24);
    // The rs number matches, but use_rs=0: no stall.
    vecs[8]  = mk(0,0,0,1,1,1,0,0,1,0,1, 11,5,12,0, 32'hCCCC0005,32'h28, 0,1,1,1,0,0,1, 12,0, 32'hCCCC0005,32'h28);
    // The rt path stalls a sw (wmem bubbled to 0), then the sw retries.
    vecs[9]  = mk(0,0,0,1,0,0,1,0,1,0,1, 0,12,0,0, 32'hDDDD0006,32'h8,   1,0,0,0,0,0,1, 0,0, 32'hDDDD0006,32'h8);
    vecs[10] = mk(0,0,0,1,0,0,1,0,1,0,1, 0,12,0,0, 32'hDDDD0006,32'h8,   0,1,0,0,1,0,1, 0,0, 32'hDDDD0006,32'h8);
    // EXE has m2reg but not wreg: no stall.
    vecs[11] = mk(0,0,0,1,0,1,0,0,0,0,0, 0,0,13,0, 32'hEEEE0007,32'h0,   0,1,0,1,0,0,0, 13,0, 32'hEEEE0007,32'h0);
    vecs[12] = mk(0,0,0,1,1,0,0,1,0,1,0, 13,0,31,0, 32'hEEEE0008,32'h0,  0,1,1,0,0,1,0, 31,0, 32'hEEEE0008,32'h0);
    // lw $14, then flush with a load-use stall: one bubble, no extra cycle.
    vecs[13] = mk(0,0,0,1,1,1,0,0,1,0,0, 0,0,14,0, 32'h11110009,32'h30,  0,1,1,1,0,0,1, 14,0, 32'h11110009,32'h30);
    vecs[14] = mk(0,0,1,1,1,0,0,0,0,1,0, 14,0,15,3, 32'h2222000A,32'h0,  1,0,0,0,0,0,0, 15,3, 32'h2222000A,32'h0);
    vecs[15] = mk(0,0,0,1,1,1,0,0,1,1,0, 14,0,16,0, 32'h3333000B,32'h40, 0,1,1,1,0,0,1, 16,0, 32'h3333000B,32'h40);
    // Hold for 3 cycles with flush in the 2nd. lu_stall is masked while held.
    vecs[16] = mk(0,1,0,1,1,0,0,0,0,1,0, 16,0,20,1, 32'h4444000C,32'h0,  0,1,1,1,0,0,1, 16,0, 32'h3333000B,32'h40);
    vecs[17] = mk(0,1,1,1,1,0,0,0,0,1,0, 16,0,20,1, 32'h4444000C,32'h0,  0,1,1,1,0,0,1, 16,0, 32'h3333000B,32'h40);
    vecs[18] = mk(0,1,0,1,1,0,0,0,0,1,0, 16,0,20,1, 32'h4444000C,32'h0,  0,1,1,1,0,0,1, 16,0, 32'h3333000B,32'h40);
    // The pending flush gives a bubble, then normal loading resumes.
    vecs[19] = mk(0,0,0,1,1,0,0,0,1,0,0, 16,0,21,6, 32'h5555000D,32'h44, 0,0,0,0,0,0,1, 21,6, 32'h5555000D,32'h44);
    vecs[20] = mk(0,0,0,1,1,0,0,0,1,0,0, 16,0,21,6, 32'h5555000D,32'h44, 0,1,1,0,0,0,1, 21,6, 32'h5555000D,32'h44);
    // Flush during hold, then reset while still held: the pending flush is dropped.
    vecs[21] = mk(0,1,1,1,1,0,0,0,0,0,0, 0,0,25,7, 32'h6666000E,32'h0,   0,1,1,0,0,0,1, 21,6, 32'h5555000D,32'h44);
    vecs[22] = mk(1,1,0,1,1,0,0,0,0,0,0, 0,0,25,7, 32'h6666000E,32'h0,   0,0,0,0,0,0,0, 0,0, 32'h0,32'h0);
    vecs[23] = mk(0,0,0,1,1,1,0,0,1,0,0, 0,0,22,0, 32'h7777000F,32'h48,  0,1,1,1,0,0,1, 22,0, 32'h7777000F,32'h48);
    // The ID slot is not valid: no stall, and e_valid follows d_valid.
    vecs[24] = mk(0,0,0,0,1,1,0,0,0,1,0, 22,0,23,9, 32'h88880010,32'h0,  0,0,1,1,0,0,0, 23,9, 32'h88880010,32'h0);

    // Initial reset so that the first lu_stall check sees defined state.
    drive(vecs[0]);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #2;
      chk(i, "lu_stall", 32'(lu_stall), 32'(vecs[i].x_lu));
      @(posedge clk);
      #1;
      chk(i, "e_valid",  32'(e_valid),  32'(vecs[i].x_valid));
      chk(i, "e_wreg",   32'(e_wreg),   32'(vecs[i].x_wreg));
      chk(i, "e_m2reg",  32'(e_m2reg),  32'(vecs[i].x_m2reg));
      chk(i, "e_wmem",   32'(e_wmem),   32'(vecs[i].x_wmem));
      chk(i, "e_jal",    32'(e_jal),    32'(vecs[i].x_jal));
      chk(i, "e_aluimm", 32'(e_aluimm), 32'(vecs[i].x_aluimm));
      chk(i, "e_shift",  32'(e_shift),  32'(vecs[i].x_aluimm));
      chk(i, "e_rn",     32'(e_rn),     32'(vecs[i].x_rn));
      chk(i, "e_aluc",   32'(e_aluc),   32'(vecs[i].x_aluc));
      chk(i, "e_qb",     e_qb,          vecs[i].x_qb);
      chk(i, "e_qa",     e_qa,          mk_qa(vecs[i].x_qb));
      chk(i, "e_imm",    e_imm,         vecs[i].x_imm);
      chk(i, "e_pc4",    e_pc4,         mk_pc4(vecs[i].x_imm));
      $display("vec %0d: rst=%0b hold=%0b flush=%0b -> e_valid=%0b e_wreg=%0b e_m2reg=%0b e_rn=%0d e_qb=%h",
               i, vecs[i].rst, vecs[i].hold, vecs[i].flush, e_valid, e_wreg, e_m2reg, e_rn, e_qb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
